// File: rtl/if_prefetch_stage_pkg.sv
// Shared definitions for the mips_16 instruction-fetch stage: fetch FSM encoding and the NOP word.
package if_prefetch_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue: synchronous FIFO with push/pop/flush and an occupancy count.
// Flush wins over push and pop. Push and pop together are legal when full.
module if_prefetch_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !flush;
  assign w_pop  = pop && !flush && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/if_prefetch_stage.sv
// mips_16 fetch stage: owns the fetch PC, reads imem over req/ack, buffers words for decode.
//   state     | meaning
//   S_IDLE    | no request outstanding (queue full or just reset)
//   S_REQ     | request for fetch_pc outstanding
//   S_DISCARD | request for a pre-branch address outstanding; its data is dropped
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  input  logic                instruction_decode_en,
  input  logic                branch_taken,
  input  logic [5:0]          branch_offset_imm,
  output logic [15:0]         instruction,
  output logic [PC_WIDTH-1:0] instruction_pc,
  output logic                fetch_valid
);

  localparam int unsigned QW = PC_WIDTH + 16;
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PC_WIDTH-1:0] r_stale_addr;
  logic [PC_WIDTH-1:0] r_id_pc;
  logic [PC_WIDTH-1:0] w_target;
  logic [PC_WIDTH-1:0] w_head_pc;
  logic [15:0]         w_head_instr;
  logic [QW-1:0]       w_head;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_count_after_pop;
  logic [CW-1:0]       w_count_after_push;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_head_live;

  // A taken branch hides the head (no delay slot) and blocks both pop and push.
  assign w_head_live        = !w_empty && !branch_taken;
  assign w_pop              = instruction_decode_en && w_head_live;
  assign w_push             = (r_state == S_REQ) && imem_ack && !branch_taken;
  assign w_count_after_pop  = w_count - CW'(w_pop);
  assign w_count_after_push = w_count_after_pop + CW'(w_push);
  assign w_target           = r_id_pc + PC_WIDTH'(1) + PC_WIDTH'($signed(branch_offset_imm));
  assign {w_head_pc, w_head_instr} = w_head;

  if_prefetch_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (branch_taken),
    .din   ({r_fetch_pc, imem_rdata}),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (branch_taken || (w_count_after_pop < DEPTH_CNT)) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (branch_taken)                                      w_state_nxt = imem_ack ? S_REQ : S_DISCARD;
        else if (imem_ack && (w_count_after_push >= DEPTH_CNT)) w_state_nxt = S_IDLE;
      end
      S_DISCARD: begin
        if (imem_ack) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_fetch_pc;
    case (r_state)
      S_REQ:     imem_req = 1'b1;
      S_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = r_stale_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc   <= PC_WIDTH'(RESET_PC);
      r_stale_addr <= '0;
      r_id_pc      <= '0;
    end else begin
      if (branch_taken)  r_fetch_pc <= w_target;
      else if (w_push)   r_fetch_pc <= r_fetch_pc + PC_WIDTH'(1);
      // The memory still owes a reply for this address; keep presenting it until ack.
      if (branch_taken && (r_state == S_REQ) && !imem_ack) r_stale_addr <= r_fetch_pc;
      if (w_pop)         r_id_pc <= w_head_pc;
    end
  end

  assign instruction    = w_head_live ? w_head_instr : NOP_WORD;
  assign instruction_pc = w_head_live ? w_head_pc : '0;
  assign fetch_valid    = w_head_live;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed latency/stall/branch/reset cases, then random traffic
// scored against an in-order program-stream model with a variable-latency memory.
module tb_if_prefetch_stage;

  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [15:0]   imem_rdata = '0;
  logic          instruction_decode_en = 1'b0;
  logic          branch_taken = 1'b0;
  logic [5:0]    branch_offset_imm = '0;
  logic [15:0]   instruction;
  logic [PW-1:0] instruction_pc;
  logic          fetch_valid;

  if_prefetch_stage #(.PC_WIDTH(PW), .DEPTH(2), .RESET_PC(0)) u_dut (
    .clk                   (clk),
    .rst                   (rst),
    .imem_req              (imem_req),
    .imem_addr             (imem_addr),
    .imem_ack              (imem_ack),
    .imem_rdata            (imem_rdata),
    .instruction_decode_en (instruction_decode_en),
    .branch_taken          (branch_taken),
    .branch_offset_imm     (branch_offset_imm),
    .instruction           (instruction),
    .instruction_pc        (instruction_pc),
    .fetch_valid           (fetch_valid)
  );

  always #5 clk = ~clk;

  logic [15:0]   rom [256];
  int            n_chk = 0;
  int            n_err = 0;
  bit            rst_cmd = 1'b1;
  int            lat_fix = 0;
  bit            mem_stall = 1'b0;
  bit            in_prog = 1'b0;
  logic [PW-1:0] held_addr = '0;
  int            wait_left = 0;
  logic [PW-1:0] exp_pc = '0;
  logic [PW-1:0] id_pc_m = '0;
  bit            have_id = 1'b0;
  int            delivered = 0;
  int            bubbles = 0;
  int            gap = 0;
  bit            chk_live = 1'b0;
  bit            found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, play memory, settle, score the offered word.
  task automatic step(input bit de, input bit br, input logic [5:0] off);
    @(negedge clk);
    rst                   = rst_cmd;
    instruction_decode_en = de;
    branch_taken          = br;
    branch_offset_imm     = off;
    imem_ack              = 1'b0;
    imem_rdata            = 16'($urandom);
    if (rst_cmd || !imem_req) begin
      in_prog = 1'b0;
    end else begin
      if (!in_prog) begin
        in_prog   = 1'b1;
        held_addr = imem_addr;
        wait_left = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      end else begin
        chk("addr_hold", imem_addr, held_addr);
      end
      if (!mem_stall && wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = rom[held_addr];
        in_prog    = 1'b0;
      end else if (wait_left > 0) begin
        wait_left--;
      end
    end
    #1;
    if (rst_cmd) begin
      exp_pc  = '0;
      id_pc_m = '0;
      have_id = 1'b0;
      gap     = 0;
    end else begin
      gap++;
      if (!fetch_valid) bubbles++;
      if (br) begin
        chk("br_nop", instruction, 16'h0000);
        exp_pc = id_pc_m + 8'd1 + {{2{off[5]}}, off};
      end else if (fetch_valid) begin
        chk("pc", instruction_pc, exp_pc);
        chk("instr", instruction, rom[exp_pc]);
        if (de) begin
          id_pc_m = exp_pc;
          exp_pc  = exp_pc + 8'd1;
          have_id = 1'b1;
          delivered++;
          gap = 0;
        end
      end else begin
        chk("bubble_instr", instruction, 16'h0000);
        chk("bubble_pc", instruction_pc, 0);
      end
      if (chk_live && gap > 60) begin
        chk("starve", gap, 0);
        gap = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst_cmd = 1'b1;
    step(0, 0, '0);
    step(0, 0, '0);
    rst_cmd = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) rom[k] = 16'h1000 + 16'(k);

    // Reset state
    do_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_pc", instruction_pc, 0);
    chk("rst_valid", fetch_valid, 0);

    // Zero-wait memory: two-cycle startup then one word per cycle
    lat_fix = 0;
    for (int c = 0; c < 10; c++) begin
      step(1, 0, '0);
      chk("zw_req", imem_req, (c >= 1) ? 1 : 0);
      if (c >= 1) chk("zw_addr", imem_addr, c - 1);
      chk("zw_valid", fetch_valid, (c >= 2) ? 1 : 0);
      if (c >= 2) chk("zw_pc", instruction_pc, c - 2);
    end

    // Three-cycle memory latency: 9 words in 30 cycles, bubbles in between
    do_reset();
    lat_fix   = 2;
    delivered = 0;
    bubbles   = 0;
    for (int c = 0; c < 30; c++) step(1, 0, '0);
    chk("lat3_count", delivered, 9);
    chk("lat3_bubbles", bubbles, 21);

    // Decode stall fills the queue and parks the requester
    do_reset();
    lat_fix = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 0, '0);
      if (c == 3) chk("stall_req_drop", imem_req, 0);
    end
    chk("stall_req", imem_req, 0);
    chk("stall_valid", fetch_valid, 1);
    for (int c = 0; c < 3; c++) begin
      step(1, 0, '0);
      chk("stall_release_pc", instruction_pc, c);
      if (c == 1) chk("stall_refetch_addr", imem_addr, 2);
    end

    // Branch back by 2 from pc 5 while addr 7 is outstanding without ack
    do_reset();
    lat_fix = 0;
    for (int c = 0; c < 8; c++) step(1, 0, '0);
    chk("br1_pre_pc", instruction_pc, 5);
    mem_stall = 1'b1;
    step(1, 1, 6'b111110);
    chk("br1_addr_at_branch", imem_addr, 7);
    step(1, 0, '0);
    chk("br1_discard_req", imem_req, 1);
    chk("br1_discard_addr", imem_addr, 7);
    chk("br1_flushed", fetch_valid, 0);
    mem_stall = 1'b0;
    step(1, 0, '0);
    chk("br1_drop_valid", fetch_valid, 0);
    step(1, 0, '0);
    chk("br1_target_addr", imem_addr, 4);
    step(1, 0, '0);
    chk("br1_target_valid", fetch_valid, 1);
    chk("br1_target_pc", instruction_pc, 4);

    // Branch from pc 8'hFE wraps to 8'h02, coincident with an ack
    do_reset();
    lat_fix = 0;
    found   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step(1, 0, '0);
      if (fetch_valid && instruction_pc == 8'hFE) begin
        found = 1'b1;
        break;
      end
    end
    chk("br2_reach_fe", found, 1);
    step(1, 1, 6'b000011);
    chk("br2_addr_at_branch", imem_addr, 8'h00);
    step(1, 0, '0);
    chk("br2_target_addr", imem_addr, 8'h02);
    chk("br2_no_push", fetch_valid, 0);
    step(1, 0, '0);
    chk("br2_target_pc", instruction_pc, 8'h02);

    // Reset while a request is live and the queue is filling
    do_reset();
    lat_fix = 0;
    step(0, 0, '0);
    step(0, 0, '0);
    rst_cmd = 1'b1;
    step(0, 0, '0);
    chk("mrst_req_before", imem_req, 1);
    rst_cmd = 1'b0;
    step(0, 0, '0);
    chk("mrst_req", imem_req, 0);
    chk("mrst_instr", instruction, 16'h0000);
    chk("mrst_valid", fetch_valid, 0);
    chk("mrst_addr", imem_addr, 0);
    step(1, 0, '0);
    chk("mrst_refetch_addr", imem_addr, 0);
    for (int c = 0; c < 4; c++) step(1, 0, '0);

    // Random traffic: variable latency, random stalls and branches
    do_reset();
    lat_fix   = -1;
    chk_live  = 1'b1;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0,
           have_id && ($urandom_range(0, 11) == 0),
           6'($urandom));
    end
    chk_live = 1'b0;
    chk("rand_progress", delivered >= 400, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
